// File: rtl/fsm_bit_serializer.sv
// Parallel-to-serial front end for the 010 sequence detector: words arrive on a
// valid/ready handshake and leave one bit per clock on x, with idle gaps between frames.
module fsm_bit_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_BIT   = 1'b1,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             last,
  output logic [9:0]       frame_count
);

  localparam int unsigned   CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    GAP_LEN  = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t          state_r;
  logic [WIDTH-1:0] shift_r;
  logic [CW-1:0]   cnt_r;
  logic [3:0]      gap_r;
  logic            x_r;
  logic            x_valid_r;
  logic            last_r;
  logic [9:0]      frame_count_r;
  logic            din_ready_s;
  logic            accept_s;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) first_bit = w[WIDTH-1];
    else           first_bit = w[0];
  endfunction

  // The shift register keeps only the bits still to be sent, so the next bit sits at the same end.
  function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) drop_bit = w << 1;
    else           drop_bit = w >> 1;
  endfunction

  // Ready decode: idle, or the final bit of a frame when frames may abut
  always_comb begin
    din_ready_s = 1'b0;
    if (state_r == ST_IDLE) begin
      din_ready_s = 1'b1;
    end else if ((state_r == ST_SHIFT) && (cnt_r == LAST_CNT) && (GAP_CYCLES == 32'd0)) begin
      din_ready_s = 1'b1;
    end else begin
      din_ready_s = 1'b0;
    end
  end

  assign accept_s    = din_valid & din_ready_s;
  assign din_ready   = din_ready_s;
  assign x           = x_r;
  assign x_valid     = x_valid_r;
  assign last        = last_r;
  assign frame_count = frame_count_r;

  // Frame sequencer: state, shift register, counters and registered line outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      shift_r       <= '0;
      cnt_r         <= '0;
      gap_r         <= 4'd0;
      x_r           <= IDLE_BIT;
      x_valid_r     <= 1'b0;
      last_r        <= 1'b0;
      frame_count_r <= 10'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r   <= ST_SHIFT;
            shift_r   <= drop_bit(din);
            cnt_r     <= '0;
            x_r       <= first_bit(din);
            x_valid_r <= 1'b1;
            last_r    <= 1'b0;
          end else begin
            x_r       <= IDLE_BIT;
            x_valid_r <= 1'b0;
            last_r    <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (cnt_r == LAST_CNT) begin
            frame_count_r <= frame_count_r + 10'd1;
            if (accept_s) begin
              // Abutting frame: first bit of the next word follows with no idle bit
              shift_r   <= drop_bit(din);
              cnt_r     <= '0;
              x_r       <= first_bit(din);
              x_valid_r <= 1'b1;
              last_r    <= 1'b0;
            end else if (GAP_CYCLES != 32'd0) begin
              state_r   <= ST_GAP;
              gap_r     <= GAP_LEN - 4'd1;
              x_r       <= IDLE_BIT;
              x_valid_r <= 1'b0;
              last_r    <= 1'b0;
            end else begin
              state_r   <= ST_IDLE;
              x_r       <= IDLE_BIT;
              x_valid_r <= 1'b0;
              last_r    <= 1'b0;
            end
          end else begin
            cnt_r     <= cnt_r + CNT_ONE;
            x_r       <= first_bit(shift_r);
            shift_r   <= drop_bit(shift_r);
            x_valid_r <= 1'b1;
            last_r    <= ((cnt_r + CNT_ONE) == LAST_CNT);
          end
        end
        ST_GAP: begin
          x_r       <= IDLE_BIT;
          x_valid_r <= 1'b0;
          last_r    <= 1'b0;
          if (gap_r == 4'd0) begin
            state_r <= ST_IDLE;
          end else begin
            gap_r <= gap_r - 4'd1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          x_r       <= IDLE_BIT;
          x_valid_r <= 1'b0;
          last_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fsm_bit_serializer.md
Name: fsm_bit_serializer

Overview:
Parallel-to-serial stage that sits directly upstream of the 010 sequence detector and drives its serial input x.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock.
- Drives the line to an idle level between words, so the detector parks in its idle state.
- Counts completed frames for correlation against the detector's count.

Parameters:
WIDTH, 8, word width in bits (legal range 2..64)
MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first
IDLE_BIT, 1, level driven on x when no frame bit is active
GAP_CYCLES, 1, number of idle-bit cycles inserted after each frame (0..15)

Ports:
clk  in  1  system clock, rising-edge active
rst  in  1  asynchronous active-low reset
din  in  WIDTH  parallel word to serialize
din_valid  in  1  din holds a word to send
din_ready  out  1  block can accept din this cycle
x  out  1  serial bit to downstream detector
x_valid  out  1  x carries a frame bit (not idle/gap)
last  out  1  x carries the final bit of the current frame
frame_count  out  10  completed frames, modulo 1024

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - state=IDLE, x=IDLE_BIT, x_valid=0, last=0, frame_count=0.
  - Shift register and bit counter cleared.
  - din_ready=1 once in IDLE.
- Release: synchronous to clk.
- States: IDLE, SHIFT, GAP.
- All outputs are registered except din_ready, which is decoded combinationally from state and bit counter.
- din_ready=1 in the following cases, otherwise 0:
  - in IDLE;
  - in SHIFT during the last-bit cycle, only when GAP_CYCLES=0.
- Accept: din captured at the rising edge where din_valid=1 and din_ready=1.
  - din_valid while din_ready=0 is ignored; the word is not latched.
  - Upstream must hold din_valid/din until accepted.
- IDLE -> SHIFT on accept.
  - From that edge: x = first bit (din[WIDTH-1] if MSB_FIRST, else din[0]) and x_valid=1.
  - Latency: accept edge to first bit = 0 extra cycles.
- SHIFT: one bit per clock for exactly WIDTH cycles.
  - Bit counter runs 0..WIDTH-1.
  - last=1 only while counter=WIDTH-1.
- On the edge ending the last-bit cycle:
  - frame_count increments by 1, wrapping 1023 -> 0.
  - If a new word is accepted on that same edge (GAP_CYCLES=0 only), go SHIFT with the new word's first bit and counter 0. No idle bit is inserted.
  - Else if GAP_CYCLES>0, go GAP.
  - Else go IDLE.
- GAP: x=IDLE_BIT, x_valid=0, last=0, din_ready=0 for exactly GAP_CYCLES cycles, then IDLE.
- IDLE: x=IDLE_BIT, x_valid=0, last=0.
- Reset mid-frame: frame aborted, not counted; all outputs return to reset values immediately.
- Width rules:
  - Bit counter is $clog2(WIDTH) bits; gap counter is 4 bits.
  - frame_count is a 10-bit unsigned wrapping counter with no saturation.
- x must never be X/Z after reset release.

Test Plan:
1. Reset: hold rst=0 for 3 clocks, assert mid-cycle -> x=1, x_valid=0, last=0, din_ready=1, frame_count=0 immediately, with no edge needed.
2. Defaults, din=8'b0100_0000:
   - x = 0,1,0,0,0,0,0,0 over 8 cycles with x_valid=1; last=1 on the 8th only.
   - Then one GAP cycle (x=1, din_ready=0), then IDLE.
   - frame_count=1; downstream detector sees exactly one 010.
3. MSB_FIRST=0, din=8'hA5 -> x = 1,0,1,0,0,1,0,1; frame_count=1.
4. GAP_CYCLES=0, din_valid held high with 8'hFF then 8'h00:
   - 16 contiguous x_valid=1 cycles, x = eight 1s then eight 0s.
   - din_ready=1 only in IDLE and in cycle 8; last=1 in cycles 8 and 16.
   - frame_count=2.
5. Reset mid-frame: assert rst=0 after 3 bits of 8'hC3.
   - Outputs return to reset values at once and frame_count stays 0.
   - After release, 8'h3C transmits in full and frame_count=1.
6. Back-to-back frames with din_valid pulsed during SHIFT/GAP:
   - Pulses during SHIFT/GAP are ignored.
   - After 1024 accepted frames, frame_count wraps to 0.
   - x=IDLE_BIT in every non-frame cycle.
